// File: rtl/parallel_bus_memory_slave_pkg.sv
// parallel_bus_memory_slave_pkg: shared mode and FSM state encodings for the parallel-bus memory slave
package parallel_bus_memory_slave_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    MODE_ADDRESS,
    MODE_WRITE,
    MODE_READ
  } mode_t;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    FETCH,
    ACK
  } state_t;

  // read wins over register_select: any read is a data read
  function automatic mode_t decode_mode(input logic rd, input logic rs);
    return rd ? MODE_READ : (rs ? MODE_WRITE : MODE_ADDRESS);
  endfunction

endpackage

// File: rtl/parallel_bus_memory_slave_ram.sv
// parallel_bus_memory_slave_ram: simple dual-port RAM with registered read, contents not reset
module parallel_bus_memory_slave_ram #(
  parameter int addr_width = 10,
  parameter int data_width = 32
) (
  input  logic                  wclk,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [data_width-1:0] wdata,
  input  logic                  rclk,
  input  logic [addr_width-1:0] raddr,
  output logic [data_width-1:0] rdata
);

  logic [data_width-1:0] mem [2**addr_width];

  // write port
  always_ff @(posedge wclk)
    if (we) mem[waddr] <= wdata;

  // registered read port
  always_ff @(posedge rclk)
    rdata <= mem[raddr];

endmodule

// File: rtl/parallel_bus_memory_slave.sv
// parallel_bus_memory_slave: multi-transaction parallel-bus slave with pollable RAM (optional PARALLEL_BUS_AUTOINCREMENT_EN)
module parallel_bus_memory_slave
  import parallel_bus_memory_slave_pkg::*;
#(
  parameter int WIDTH                = DEFAULT_WIDTH,
  parameter int ADDRESS_TRANSACTIONS = 2,
  parameter int DATA_TRANSACTIONS    = 4,
  parameter int ADDRESS_DEPTH_BITS   = 10,
  parameter int ERROR_COUNTER_WIDTH  = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [WIDTH-1:0]               bus_in,
  output logic [WIDTH-1:0]               bus_out,
  output logic                           bus_oe,
  input  logic                           read,
  input  logic                           register_select,
  input  logic                           enable,
  output logic                           ack_valid,
  output logic [ERROR_COUNTER_WIDTH-1:0] error_count,
  output logic [7:0]                     leds
);

  localparam int WORD = DATA_TRANSACTIONS * WIDTH;
  localparam int ACW  = $clog2(ADDRESS_TRANSACTIONS + 1);
  localparam int DCW  = $clog2(DATA_TRANSACTIONS + 1);
  localparam logic [ACW-1:0] A_LAST = ACW'(ADDRESS_TRANSACTIONS - 1);
  localparam logic [DCW-1:0] D_LAST = DCW'(DATA_TRANSACTIONS - 1);

  logic [1:0] read_q, rs_q, en_q;
  logic read_s, rs_s, enable_s;
  state_t state;
  mode_t mode, bus_mode;
  logic [ACW-1:0] aword;
  logic [DCW-1:0] wword, rword;
  logic [ADDRESS_DEPTH_BITS-1:0] address;
  logic [WORD-1:0] data_word, rdata;
  logic write_strobe, err;

  assign read_s   = read_q[1];
  assign rs_s     = rs_q[1];
  assign enable_s = en_q[1];
  assign bus_mode = decode_mode(read_s, rs_s);
  assign bus_oe   = read_s & ~reset;
  assign err = state == DECODE &&
    (bus_mode == MODE_ADDRESS ? (wword != D_LAST || rword != D_LAST)
                              : (aword != A_LAST ||
                                 (bus_mode == MODE_WRITE ? rword != D_LAST : wword != D_LAST)));

  // two-flop synchronisers for the asynchronous control strobes
  always_ff @(posedge clock)
    if (reset) begin
      read_q <= '0;
      rs_q   <= '0;
      en_q   <= '0;
    end else begin
      read_q <= {read_q[0], read};
      rs_q   <= {rs_q[0], register_select};
      en_q   <= {en_q[0], enable};
    end

  // bus transaction FSM: part counters run N-1 down to 0, most-significant part first
  always_ff @(posedge clock)
    if (reset) begin
      state        <= IDLE;
      mode         <= MODE_ADDRESS;
      aword        <= A_LAST;
      wword        <= D_LAST;
      rword        <= D_LAST;
      address      <= '0;
      data_word    <= '0;
      write_strobe <= 1'b0;
      ack_valid    <= 1'b0;
      bus_out      <= '0;
      leds         <= '0;
    end else begin
      write_strobe <= 1'b0;
      case (state)
        IDLE: if (enable_s) state <= DECODE;
        DECODE: begin
          mode <= bus_mode;
          case (bus_mode)
            MODE_ADDRESS: begin
              for (int i = 0; i < ADDRESS_DEPTH_BITS; i++)
                if (i / WIDTH == int'(aword)) address[i] <= bus_in[i % WIDTH];
              wword     <= D_LAST;
              rword     <= D_LAST;
              ack_valid <= 1'b1;
              state     <= ACK;
            end
            MODE_WRITE: begin
              data_word[int'(wword)*WIDTH +: WIDTH] <= bus_in;
              leds         <= 8'(bus_in);
              write_strobe <= wword == '0;
              rword        <= D_LAST;
              ack_valid    <= 1'b1;
              state        <= ACK;
            end
            default: begin
              wword <= D_LAST;
              state <= FETCH;
            end
          endcase
        end
        FETCH: begin
          bus_out   <= rdata[int'(rword)*WIDTH +: WIDTH];
          ack_valid <= 1'b1;
          state     <= ACK;
        end
        ACK: if (!enable_s) begin
          ack_valid <= 1'b0;
          state     <= IDLE;
          case (mode)
            MODE_ADDRESS: aword <= aword == '0 ? A_LAST : aword - 1'b1;
            MODE_WRITE:   wword <= wword == '0 ? D_LAST : wword - 1'b1;
            default:      rword <= rword == '0 ? D_LAST : rword - 1'b1;
          endcase
`ifdef PARALLEL_BUS_AUTOINCREMENT_EN
          if (mode != MODE_ADDRESS && (mode == MODE_WRITE ? wword == '0 : rword == '0))
            address <= address + 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end

  // saturating protocol-error counter, one increment per offending transaction
  always_ff @(posedge clock)
    if (reset) error_count <= '0;
    else if (err && error_count != '1) error_count <= error_count + 1'b1;

  parallel_bus_memory_slave_ram #(
    .addr_width(ADDRESS_DEPTH_BITS),
    .data_width(WORD)
  ) u_ram (
    .wclk (clock),
    .we   (write_strobe & ~reset),
    .waddr(address),
    .wdata(data_word),
    .rclk (clock),
    .raddr(address),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_parallel_bus_memory_slave.sv
// tb_parallel_bus_memory_slave: directed and randomized checks against a transaction-level model
module tb_parallel_bus_memory_slave;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [7:0] bus_in = '0;
  logic [7:0] bus_out;
  logic bus_oe;
  logic read = 1'b0;
  logic register_select = 1'b0;
  logic enable = 1'b0;
  logic ack_valid;
  logic [15:0] error_count;
  logic [7:0] leds;

  int n_assert = 0;
  int n_fail = 0;

  bit [31:0] mem_m [1024];
  bit        vld_m [1024];
  int a_cnt, w_cnt, r_cnt, err_m;
  bit [15:0] addr_m;
  bit [31:0] wbuf;
  bit [7:0]  leds_m;

  always #5 clock = ~clock;

  parallel_bus_memory_slave dut (
    .clock(clock),
    .reset(reset),
    .bus_in(bus_in),
    .bus_out(bus_out),
    .bus_oe(bus_oe),
    .read(read),
    .register_select(register_select),
    .enable(enable),
    .ack_valid(ack_valid),
    .error_count(error_count),
    .leds(leds)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    a_cnt = 0;
    w_cnt = 0;
    r_cnt = 0;
    err_m = 0;
    addr_m = '0;
    leds_m = '0;
  endtask

  task automatic model_advance();
`ifdef PARALLEL_BUS_AUTOINCREMENT_EN
    addr_m[9:0] = addr_m[9:0] + 10'd1;
`endif
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    enable = 1'b0;
    read = 1'b0;
    register_select = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    check("rst_ack", ack_valid, 0);
    check("rst_oe", bus_oe, 0);
    check("rst_err", error_count, 0);
    check("rst_leds", leds, 0);
    check("rst_bus_out", bus_out, 0);
  endtask

  // one bus transaction, checked against the model
  task automatic part(input bit rd, input bit rs, input logic [7:0] v, output logic [7:0] got);
    bit e;
    int lat, n;
    int idx;
    bit chk;
    logic [7:0] exp_rd;
    e = 0;
    if (!rd && !rs) begin
      if (w_cnt != 0 || r_cnt != 0) e = 1;
      w_cnt = 0;
      r_cnt = 0;
    end else begin
      if (a_cnt != 0) e = 1;
      if (!rd && r_cnt != 0) begin e = 1; r_cnt = 0; end
      if (rd && w_cnt != 0) begin e = 1; w_cnt = 0; end
    end
    if (e && err_m < 65535) err_m++;
    idx = int'(addr_m[9:0]);
    chk = vld_m[idx];
    exp_rd = mem_m[idx][(3 - r_cnt)*8 +: 8];
    @(negedge clock);
    read = rd;
    register_select = rs;
    bus_in = v;
    enable = 1'b1;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!ack_valid && lat < 20);
    check(rd ? "rd_latency" : "wr_latency", lat, rd ? 5 : 4);
    got = bus_out;
    check("bus_oe", bus_oe, rd);
    if (rd && chk) check("rd_data", got, exp_rd);
    check("err_count", error_count, err_m);
    if (rd) begin
      r_cnt++;
      if (r_cnt == 4) begin r_cnt = 0; model_advance(); end
    end else if (rs) begin
      wbuf[(3 - w_cnt)*8 +: 8] = v;
      leds_m = v;
      w_cnt++;
      if (w_cnt == 4) begin
        mem_m[idx] = wbuf;
        vld_m[idx] = 1'b1;
        w_cnt = 0;
        model_advance();
      end
    end else begin
      addr_m[(1 - a_cnt)*8 +: 8] = v;
      a_cnt = (a_cnt + 1) % 2;
    end
    check("leds", leds, leds_m);
    enable = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (ack_valid && n < 20);
    check("ack_drop", ack_valid, 0);
  endtask

  task automatic set_addr(input logic [15:0] a);
    logic [7:0] g;
    part(0, 0, a[15:8], g);
    part(0, 0, a[7:0], g);
  endtask

  task automatic write_word(input logic [31:0] w);
    logic [7:0] g;
    for (int k = 3; k >= 0; k--) part(0, 1, w[k*8 +: 8], g);
  endtask

  task automatic read_word(output logic [31:0] w);
    logic [7:0] g;
    for (int k = 3; k >= 0; k--) begin
      part(1, 0, 8'($urandom), g);
      w[k*8 +: 8] = g;
    end
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] words [4];
    logic [7:0] g;
    words = '{32'hA1B2C312, 32'hD4E5F634, 32'h07182956, 32'h3A4B5C78};
    model_reset();
    do_reset();

    set_addr(16'h004c);
    write_word(32'h31232a12);
    set_addr(16'h004c);
    read_word(w);
    check("t1_word", w, 32'h31232a12);
    check("t1_err", error_count, 0);

    for (int i = 0; i < 4; i++) begin
      set_addr(16'h004c + 16'(i));
      write_word(words[i]);
      check("t2_leds", leds, words[i][7:0]);
    end
    for (int i = 3; i >= 0; i--) begin
      set_addr(16'h004c + 16'(i));
      read_word(w);
      check("t2_word", w, words[i]);
    end

    do_reset();
    part(0, 1, 8'h11, g);
    part(0, 1, 8'h22, g);
    part(0, 0, 8'h00, g);
    check("t3_err", error_count, 1);
    part(0, 0, 8'h10, g);
    write_word(32'hCAFE0010);
    set_addr(16'h0010);
    read_word(w);
    check("t3_word", w, 32'hCAFE0010);
    check("t3_err_end", error_count, 1);

    do_reset();
    set_addr(16'h004c);
    part(1, 0, 8'h00, g);
    part(1, 0, 8'h00, g);
    part(0, 1, 8'h99, g);
    check("t4_err", error_count, 1);
    part(0, 1, 8'h88, g);
    part(0, 1, 8'h77, g);
    part(0, 1, 8'h66, g);
    set_addr(16'h004c);
    read_word(w);
    check("t4_word", w, 32'h99887766);
    check("t4_err_end", error_count, 1);

`ifdef PARALLEL_BUS_AUTOINCREMENT_EN
    set_addr(16'h03ff);
    write_word(32'h5A5A0001);
    write_word(32'hA5A50002);
    set_addr(16'h03ff);
    read_word(w);
    check("t5_word_3ff", w, 32'h5A5A0001);
    read_word(w);
    check("t5_word_000", w, 32'hA5A50002);
`endif

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0, 1: set_addr(16'($urandom_range(0, 7)) | (16'($urandom_range(0, 3)) << 12));
        2, 3, 4: write_word($urandom);
        5, 6, 7: read_word(w);
        default: part(1'($urandom), 1'($urandom), 8'($urandom), g);
      endcase
    end

    @(negedge clock);
    read = 1'b1;
    register_select = 1'b0;
    enable = 1'b1;
    repeat (4) @(negedge clock);
    check("t6_pre_ack", ack_valid, 0);
    reset = 1'b1;
    @(negedge clock);
    check("t6_ack", ack_valid, 0);
    check("t6_oe", bus_oe, 0);
    enable = 1'b0;
    read = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    check("t6_err", error_count, 0);
    set_addr(16'h004c);
    read_word(w);
    check("t6_word", w, 32'h99887766);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
